seg_scan_controller: RTL

Time-multiplexes one 7-segment decoder across the four digits of the board display. It cycles the anode selector with a fixed per-digit slot and a blanking gap to stop ghosting. Software or the counter logic writes four BCD digits into a pending buffer, which is applied only at frame boundaries so the display never shows a half-updated frame. The block sits between the counter/datapath and the `seg`/`an` pins, and replaces any hard-wired single-digit anode.

---
 rtl/seg_scan_controller.sv | 111 +++++++++++
 1 files changed

// File: rtl/seg_scan_controller.sv
// seg_scan_controller: four-digit multiplexed 7-segment scanner with blanking gap and frame-synchronous buffer update
// Ports: clk, rst_n (async active-low); wr_en/wr_data/wr_dp/wr_digit_en load the pending buffer;
// seg/dp/an drive the active-low display pins; frame_tick pulses at each frame boundary; pending flags a queued write.
// Optional macro LEADING_ZERO_BLANK_EN suppresses digits above the most significant nonzero nibble.
module seg_scan_controller #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  input  logic [3:0]  wr_digit_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick,
  output logic        pending
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] ON_LAST = CW'(REFRESH_DIV - BLANK_CYCLES - 1);
  typedef enum logic {ON, BLANK} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0] idx;
  logic wrap, boundary, shown;
  logic [15:0] pend_data, act_data;
  logic [3:0] pend_dp, pend_en, act_dp, act_en, act_keep, keep, nib, an_nxt;
  logic [6:0] seg_nxt;
  logic dp_nxt;
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0: decode = 7'b1000000;
      4'd1: decode = 7'b1111001;
      4'd2: decode = 7'b0100100;
      4'd3: decode = 7'b0110000;
      4'd4: decode = 7'b0011001;
      4'd5: decode = 7'b0010010;
      4'd6: decode = 7'b0000010;
      4'd7: decode = 7'b1111000;
      4'd8: decode = 7'b0000000;
      4'd9: decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction
  always_comb begin
    wrap      = cnt == LAST;
    boundary  = wrap && idx == 2'd3;
    cnt_nxt   = wrap ? '0 : cnt + 1'b1;
    // with no blanking ON_LAST equals LAST, so BLANK is never selected
    state_nxt = cnt_nxt > ON_LAST ? BLANK : ON;
`ifdef LEADING_ZERO_BLANK_EN
    keep      = {|pend_data[15:12], |pend_data[15:8], |pend_data[15:4], 1'b1};
`else
    keep      = 4'hF;
`endif
    nib       = act_data[{idx, 2'b00} +: 4];
    // a suppressed leading digit still lights its anode when its decimal point is set
    shown     = state == ON && act_en[idx] && (act_keep[idx] || act_dp[idx]);
    an_nxt    = shown ? ~(4'b0001 << idx) : 4'b1111;
    seg_nxt   = shown && act_keep[idx] ? decode(nib) : 7'b1111111;
    dp_nxt    = ~(shown && act_dp[idx]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ON;
      cnt   <= '0;
      idx   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= wrap ? idx + 2'd1 : idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_en    <= '0;
      act_data   <= '0;
      act_dp     <= '0;
      act_en     <= '0;
      act_keep   <= 4'hF;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
    end else begin
      if (wr_en) begin
        pend_data <= wr_data;
        pend_dp   <= wr_dp;
        pend_en   <= wr_digit_en;
      end
      // the boundary applies what was pending before this cycle; a coincident write stays queued
      if (boundary && pending) begin
        act_data <= pend_data;
        act_dp   <= pend_dp;
        act_en   <= pend_en;
        act_keep <= keep;
      end
      pending    <= wr_en || (pending && !boundary);
      frame_tick <= boundary;
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
    end
  end
endmodule
